// File: rtl/pwm_capture.sv
// Receive-side PWM decoder: measures high time and period of an asynchronous
// PWM input in prescaler ticks and flags inputs that stop toggling.
module pwm_capture #(
    parameter int CNT_BITS   = 16,
    parameter int TIMER_BITS = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  pwm_in,
    input  logic [TIMER_BITS-1:0] FINAL_VALUE,
    output logic [CNT_BITS-1:0]   high_count,
    output logic [CNT_BITS-1:0]   period_count,
    output logic                  valid,
    output logic                  timeout,
    output logic                  stuck_level
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam logic [CNT_BITS-1:0]   CNT_ZERO = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0]   CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0]   CNT_MAX  = {CNT_BITS{1'b1}};
    localparam logic [TIMER_BITS-1:0] TMR_ZERO = {TIMER_BITS{1'b0}};
    localparam logic [TIMER_BITS-1:0] TMR_ONE  = {{(TIMER_BITS-1){1'b0}}, 1'b1};

    logic                  sync_meta_q;
    logic                  sync_q;
    logic                  hist_q;
    logic [1:0]            state_q,   state_d;
    logic [TIMER_BITS-1:0] tmr_q,     tmr_d;
    logic [CNT_BITS-1:0]   cnt_hi_q,  cnt_hi_d;
    logic [CNT_BITS-1:0]   cnt_per_q, cnt_per_d;
    logic [CNT_BITS-1:0]   high_q,    high_d;
    logic [CNT_BITS-1:0]   period_q,  period_d;
    logic                  valid_q,   valid_d;
    logic                  timeout_q, timeout_d;
    logic                  stuck_q,   stuck_d;
    logic                  rise_s;
    logic                  fall_s;
    logic                  tick_s;
    logic                  overflow_s;

    // Two-flop synchronizer for the pad plus one history flop for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
            hist_q      <= 1'b0;
        end else begin
            sync_meta_q <= pwm_in;
            sync_q      <= sync_meta_q;
            hist_q      <= sync_q;
        end
    end

    assign rise_s     = sync_q & ~hist_q;
    assign fall_s     = ~sync_q & hist_q;
    assign tick_s     = enable & (tmr_q == FINAL_VALUE);
    // A tick that would wrap the period counter means no edge arrived in time
    assign overflow_s = tick_s & (cnt_per_q == CNT_MAX);

    // Prescaler, measurement counters and FSM next-state logic
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        cnt_hi_d  = cnt_hi_q;
        cnt_per_d = cnt_per_q;
        high_d    = high_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        stuck_d   = stuck_q;

        if (!enable) begin
            state_d   = ST_IDLE;
            tmr_d     = TMR_ZERO;
            cnt_hi_d  = CNT_ZERO;
            cnt_per_d = CNT_ZERO;
        end else begin
            if (rise_s || tick_s) begin
                tmr_d = TMR_ZERO;
            end else begin
                tmr_d = tmr_q + TMR_ONE;
            end

            case (state_q)
                ST_IDLE: begin
                    if (rise_s) begin
                        state_d   = ST_HIGH;
                        cnt_hi_d  = CNT_ZERO;
                        cnt_per_d = CNT_ZERO;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HIGH: begin
                    if (overflow_s) begin
                        timeout_d = 1'b1;
                        stuck_d   = sync_q;
                        state_d   = ST_IDLE;
                    end else begin
                        if (tick_s) begin
                            cnt_hi_d  = cnt_hi_q + CNT_ONE;
                            cnt_per_d = cnt_per_q + CNT_ONE;
                        end else begin
                            cnt_hi_d  = cnt_hi_q;
                            cnt_per_d = cnt_per_q;
                        end
                        if (fall_s) begin
                            state_d = ST_LOW;
                        end else begin
                            state_d = ST_HIGH;
                        end
                    end
                end
                ST_LOW: begin
                    // The edge wins over a coincident tick, which is dropped
                    if (rise_s) begin
                        high_d    = cnt_hi_q;
                        period_d  = cnt_per_q;
                        valid_d   = 1'b1;
                        cnt_hi_d  = CNT_ZERO;
                        cnt_per_d = CNT_ZERO;
                        state_d   = ST_HIGH;
                    end else if (overflow_s) begin
                        timeout_d = 1'b1;
                        stuck_d   = sync_q;
                        state_d   = ST_IDLE;
                    end else if (tick_s) begin
                        cnt_per_d = cnt_per_q + CNT_ONE;
                    end else begin
                        cnt_per_d = cnt_per_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            tmr_q     <= TMR_ZERO;
            cnt_hi_q  <= CNT_ZERO;
            cnt_per_q <= CNT_ZERO;
            high_q    <= CNT_ZERO;
            period_q  <= CNT_ZERO;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            stuck_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            cnt_hi_q  <= cnt_hi_d;
            cnt_per_q <= cnt_per_d;
            high_q    <= high_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            stuck_q   <= stuck_d;
        end
    end

    assign high_count   = high_q;
    assign period_count = period_q;
    assign valid        = valid_q;
    assign timeout      = timeout_q;
    assign stuck_level  = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: table-driven measurement vectors plus
// hand-written sequences for timeout, reset and enable corner cases.
module tb_pwm_capture;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        pwm_in;
    logic [14:0] fv;
    logic [15:0] high_count, period_count;
    logic        valid, timeout, stuck_level;
    logic [7:0]  high8, period8;
    logic        valid8, timeout8, stuck8;

    int passed = 0;
    int total  = 0;
    int nvalid, ntimeout, last_hi, last_per;

    typedef struct {
        int fv;
        int hi;
        int per;
        int nper;
        int exp_hi;
        int exp_per;
        int tol;
    } vec_t;

    vec_t vecs[4];

    pwm_capture #(.CNT_BITS(16), .TIMER_BITS(15)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pwm_in(pwm_in),
        .FINAL_VALUE(fv), .high_count(high_count), .period_count(period_count),
        .valid(valid), .timeout(timeout), .stuck_level(stuck_level)
    );

    pwm_capture #(.CNT_BITS(8), .TIMER_BITS(15)) dut8 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pwm_in(pwm_in),
        .FINAL_VALUE(fv), .high_count(high8), .period_count(period8),
        .valid(valid8), .timeout(timeout8), .stuck_level(stuck8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp, input int tol);
        total++;
        if (act >= exp - tol && act <= exp + tol) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    task automatic restart();
        @(negedge clk);
        enable = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        nvalid   = 0;
        ntimeout = 0;
    endtask

    // Drives nper PWM periods; samples the 16-bit instance each cycle before driving.
    task automatic run_pwm(input int hi, input int per, input int nper);
        for (int p = 0; p < nper; p++) begin
            for (int c = 0; c < per; c++) begin
                @(negedge clk);
                if (valid) begin
                    nvalid++;
                    last_hi  = high_count;
                    last_per = period_count;
                end
                if (timeout) ntimeout++;
                pwm_in = (c < hi);
            end
        end
    endtask

    // Waits for the 8-bit instance to time out; returns cycles waited or -1.
    task automatic wait_timeout8(output int cycles);
        cycles = -1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (timeout8) begin
                cycles = n;
                break;
            end
        end
    endtask

    initial begin
        int t_at;
        int vcount[5];
        int exp_vc[5];

        // The rise-cycle tick is dropped, so a period of P ticks reads back as P-1.
        vecs[0] = '{fv: 9, hi: 250, per: 1000, nper: 3, exp_hi: 25, exp_per: 100, tol: 1};
        vecs[1] = '{fv: 0, hi: 3,   per: 7,    nper: 4, exp_hi: 3,  exp_per: 6,   tol: 0};
        vecs[2] = '{fv: 1, hi: 10,  per: 40,   nper: 3, exp_hi: 5,  exp_per: 19,  tol: 0};
        vecs[3] = '{fv: 3, hi: 256, per: 1024, nper: 3, exp_hi: 64, exp_per: 255, tol: 0};
        exp_vc  = '{0, 1, 1, 0, 1};

        reset_n = 1'b0;
        enable  = 1'b0;
        pwm_in  = 1'b0;
        fv      = 15'd0;
        last_hi = 0;
        last_per = 0;
        repeat (3) @(negedge clk);
        chk("reset_high", int'(high_count), 0, 0);
        chk("reset_period", int'(period_count), 0, 0);
        chk("reset_flags", int'({valid, timeout, stuck_level}), 0, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            fv = vecs[i].fv[14:0];
            restart();
            run_pwm(vecs[i].hi, vecs[i].per, vecs[i].nper);
            chk($sformatf("v%0d_nvalid", i), nvalid, vecs[i].nper - 1, 0);
            chk($sformatf("v%0d_high", i), last_hi, vecs[i].exp_hi, vecs[i].tol);
            chk($sformatf("v%0d_period", i), last_per, vecs[i].exp_per, vecs[i].tol);
            chk($sformatf("v%0d_timeout", i), ntimeout, 0, 0);
        end

        // Timeout with input stuck low on the 8-bit instance
        fv = 15'd0;
        restart();
        run_pwm(3, 7, 3);
        wait_timeout8(t_at);
        chk("to_low_time", t_at, 253, 3);
        chk("to_low_stuck", int'(stuck8), 0, 0);
        chk("to_low_high_held", int'(high8), 3, 0);
        chk("to_low_period_held", int'(period8), 6, 0);
        @(negedge clk);
        chk("to_low_pulse_width", int'(timeout8), 0, 0);

        // Timeout with input stuck high
        restart();
        run_pwm(3, 7, 3);
        @(negedge clk);
        pwm_in = 1'b1;
        wait_timeout8(t_at);
        chk("to_high_time", t_at, 258, 3);
        chk("to_high_stuck", int'(stuck8), 1, 0);
        chk("to_high_period_held", int'(period8), 6, 0);

        // Asynchronous reset in the middle of a high phase
        restart();
        run_pwm(3, 7, 2);
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_high", int'(high_count), 0, 0);
        chk("rst_mid_period", int'(period_count), 0, 0);
        chk("rst_mid_flags", int'({valid, timeout, stuck_level, stuck8}), 0, 0);
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        nvalid = 0;
        ntimeout = 0;
        run_pwm(3, 7, 3);
        chk("rst_after_nvalid", nvalid, 2, 0);
        chk("rst_after_high", last_hi, 3, 0);
        chk("rst_after_period", last_per, 6, 0);

        // Enable dropped for 5 clk during a low phase
        restart();
        for (int p = 0; p < 5; p++) begin
            vcount[p] = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (valid) begin
                    vcount[p]++;
                    last_hi  = high_count;
                    last_per = period_count;
                end
                if (timeout) ntimeout++;
                enable = !(p == 2 && c >= 8 && c < 13);
                pwm_in = (c < 3);
            end
        end
        for (int p = 0; p < 5; p++) begin
            chk($sformatf("en_valid_p%0d", p), vcount[p], exp_vc[p], 0);
        end
        chk("en_timeout", ntimeout, 0, 0);
        chk("en_high", last_hi, 3, 0);
        chk("en_period", last_per, 19, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
